// File: rtl/eeprom_axi_sequencer.sv
// rtl/eeprom_axi_sequencer.sv - AXI-Lite master sequencing single-byte SPI EEPROM reads and writes
// Configures the SPI peripheral once, then drives TX pushes, status polls and RX pops per request.
module eeprom_axi_sequencer #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF0000,
  parameter logic [31:0] CMD_REG_VAL  = 32'h30000000,
  parameter int          STS_BUSY_BIT = 0,
  parameter int          STS_RXNE_BIT = 1,
  parameter logic [15:0] POLL_MAX     = 16'hFFFF
) (
  input  logic        ACLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WRITE,
  input  logic [15:0] REQ_ADDR,
  input  logic [7:0]  REQ_WDATA,
  output logic        RSP_VALID,
  output logic [7:0]  RSP_RDATA,
  output logic        RSP_ERR,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] AWADDR,
  output logic        WVALID,
  input  logic        WREADY,
  output logic [31:0] WDATA,
  output logic        ARVALID,
  input  logic        ARREADY,
  output logic [31:0] ARADDR,
  input  logic        RVALID,
  output logic        RREADY,
  input  logic [31:0] RDATA
);

  localparam logic [31:0] RX_ADDR  = BASE_ADDR + 32'h0;
  localparam logic [31:0] STS_ADDR = BASE_ADDR + 32'h4;
  localparam logic [31:0] CMD_ADDR = BASE_ADDR + 32'h8;
  localparam logic [31:0] TX_ADDR  = BASE_ADDR + 32'hC;

  typedef enum logic [2:0] {
    S_CFG, S_IDLE, S_PUSH, S_DONE_WAIT, S_RX_WAIT, S_RX_POP, S_FINISH
  } state_t;
  typedef enum logic [1:0] {PH_WREN, PH_WR, PH_POLL, PH_RD} phase_t;
  typedef enum logic [1:0] {B_IDLE, B_WR, B_AR, B_R} bus_t;

  state_t      state;
  phase_t      phase;
  bus_t        bus_st;
  logic [2:0]  idx;
  logic [1:0]  pop_cnt;
  logic [15:0] poll_cnt;
  logic [15:0] req_addr_q;
  logic [7:0]  req_wdata_q;
  logic        aw_done;
  logic        w_done;

  logic [8:0]  tx_word;
  logic [2:0]  last_idx;
  logic        launch_wr;
  logic        launch_rd;
  logic [31:0] launch_addr;
  logic [31:0] launch_data;
  logic        wr_fin;
  logic        rd_fin;
  logic [16:0] poll_next;
  logic        unused_rdata;

  assign unused_rdata = ^RDATA[31:8];
  assign poll_next    = {1'b0, poll_cnt} + 17'd1;
  assign wr_fin = (bus_st == B_WR) && (aw_done || (AWVALID && AWREADY))
                                   && (w_done  || (WVALID  && WREADY));
  assign rd_fin = (bus_st == B_R) && RVALID;

  // Word idx of the current frame; bit8 marks the control word carrying the data-byte count.
  always_comb begin
    tx_word  = 9'h000;
    last_idx = 3'd4;
    case (phase)
      PH_WREN: begin
        last_idx = 3'd1;
        tx_word  = (idx == 3'd0) ? 9'h101 : 9'h006;
      end
      PH_WR: begin
        case (idx)
          3'd0:    tx_word = 9'h104;
          3'd1:    tx_word = 9'h002;
          3'd2:    tx_word = {1'b0, req_addr_q[15:8]};
          3'd3:    tx_word = {1'b0, req_addr_q[7:0]};
          default: tx_word = {1'b0, req_wdata_q};
        endcase
      end
      PH_POLL: begin
        last_idx = 3'd2;
        case (idx)
          3'd0:    tx_word = 9'h102;
          3'd1:    tx_word = 9'h005;
          default: tx_word = 9'h000;
        endcase
      end
      default: begin
        case (idx)
          3'd0:    tx_word = 9'h104;
          3'd1:    tx_word = 9'h003;
          3'd2:    tx_word = {1'b0, req_addr_q[15:8]};
          3'd3:    tx_word = {1'b0, req_addr_q[7:0]};
          default: tx_word = 9'h000;
        endcase
      end
    endcase
  end

  always_comb begin
    launch_wr   = 1'b0;
    launch_rd   = 1'b0;
    launch_addr = BASE_ADDR;
    launch_data = 32'd0;
    case (state)
      S_CFG:       begin launch_wr = 1'b1; launch_addr = CMD_ADDR; launch_data = CMD_REG_VAL; end
      S_PUSH:      begin launch_wr = 1'b1; launch_addr = TX_ADDR;  launch_data = {23'd0, tx_word}; end
      S_DONE_WAIT: begin launch_rd = 1'b1; launch_addr = STS_ADDR; end
      S_RX_WAIT:   begin launch_rd = 1'b1; launch_addr = STS_ADDR; end
      S_RX_POP:    begin launch_rd = 1'b1; launch_addr = RX_ADDR; end
      default:     ;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (RST) begin
      state       <= S_CFG;
      phase       <= PH_WREN;
      bus_st      <= B_IDLE;
      idx         <= 3'd0;
      pop_cnt     <= 2'd0;
      poll_cnt    <= 16'd0;
      req_addr_q  <= 16'd0;
      req_wdata_q <= 8'd0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      REQ_READY   <= 1'b0;
      RSP_VALID   <= 1'b0;
      RSP_RDATA   <= 8'd0;
      RSP_ERR     <= 1'b0;
      AWVALID     <= 1'b0;
      AWADDR      <= 32'd0;
      WVALID      <= 1'b0;
      WDATA       <= 32'd0;
      ARVALID     <= 1'b0;
      ARADDR      <= 32'd0;
      RREADY      <= 1'b0;
    end else begin
      RSP_VALID <= 1'b0;

      // Bus sub-FSM: one transaction at a time, AW and W retire independently.
      case (bus_st)
        B_IDLE: begin
          if (launch_wr) begin
            AWVALID <= 1'b1;
            WVALID  <= 1'b1;
            AWADDR  <= launch_addr;
            WDATA   <= launch_data;
            bus_st  <= B_WR;
          end else if (launch_rd) begin
            ARVALID <= 1'b1;
            ARADDR  <= launch_addr;
            bus_st  <= B_AR;
          end
        end
        B_WR: begin
          if (AWVALID && AWREADY) begin AWVALID <= 1'b0; aw_done <= 1'b1; end
          if (WVALID && WREADY)   begin WVALID  <= 1'b0; w_done  <= 1'b1; end
          if (wr_fin) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            bus_st  <= B_IDLE;
          end
        end
        B_AR: if (ARREADY) begin ARVALID <= 1'b0; RREADY <= 1'b1; bus_st <= B_R; end
        default: if (RVALID) begin RREADY <= 1'b0; bus_st <= B_IDLE; end
      endcase

      case (state)
        S_CFG: if (wr_fin) begin state <= S_IDLE; REQ_READY <= 1'b1; end
        S_IDLE: if (REQ_VALID) begin
          req_addr_q  <= REQ_ADDR;
          req_wdata_q <= REQ_WDATA;
          REQ_READY   <= 1'b0;
          phase       <= REQ_WRITE ? PH_WREN : PH_RD;
          idx         <= 3'd0;
          poll_cnt    <= 16'd0;
          state       <= S_PUSH;
        end
        S_PUSH: if (wr_fin) begin
          if (idx == last_idx) begin idx <= 3'd0; state <= S_DONE_WAIT; end
          else idx <= idx + 3'd1;
        end
        S_DONE_WAIT: if (rd_fin && !RDATA[STS_BUSY_BIT]) begin
          pop_cnt <= 2'd0;
          case (phase)
            PH_WREN: begin phase <= PH_WR;   state <= S_PUSH; end
            PH_WR:   begin phase <= PH_POLL; state <= S_PUSH; end
            default: state <= S_RX_WAIT;
          endcase
        end
        S_RX_WAIT: if (rd_fin && RDATA[STS_RXNE_BIT]) state <= S_RX_POP;
        S_RX_POP: if (rd_fin) begin
          pop_cnt <= pop_cnt + 2'd1;
          if (phase == PH_RD && pop_cnt == 2'd3) begin
            RSP_VALID <= 1'b1; RSP_ERR <= 1'b0; RSP_RDATA <= RDATA[7:0]; state <= S_FINISH;
          end else if (phase == PH_POLL && pop_cnt == 2'd1) begin
            // Second RDSR byte is the status register; bit0 is write-in-progress.
            if (!RDATA[0]) begin
              RSP_VALID <= 1'b1; RSP_ERR <= 1'b0; RSP_RDATA <= 8'd0; state <= S_FINISH;
            end else if (poll_next >= {1'b0, POLL_MAX}) begin
              RSP_VALID <= 1'b1; RSP_ERR <= 1'b1; RSP_RDATA <= 8'd0; state <= S_FINISH;
            end else begin
              poll_cnt <= poll_next[15:0];
              state    <= S_PUSH;
            end
          end else begin
            state <= S_RX_WAIT;
          end
        end
        S_FINISH: begin state <= S_IDLE; REQ_READY <= 1'b1; end
        default:  state <= S_CFG;
      endcase
    end
  end

endmodule

// File: tb/tb_eeprom_axi_sequencer.sv
// tb/tb_eeprom_axi_sequencer.sv - scoreboard bench with SPI peripheral and 25AA160-style EEPROM model
module tb_eeprom_axi_sequencer;

  localparam logic [31:0] BASE = 32'hFFFF0000;

  logic        ACLK = 1'b0;
  logic        RST  = 1'b1;
  logic        REQ_VALID, REQ_READY, REQ_WRITE;
  logic [15:0] REQ_ADDR;
  logic [7:0]  REQ_WDATA;
  logic        RSP_VALID, RSP_ERR;
  logic [7:0]  RSP_RDATA;
  logic        AWVALID, WVALID, ARVALID, RREADY;
  logic        AWREADY = 1'b0, WREADY = 1'b0, ARREADY = 1'b0, RVALID = 1'b0;
  logic [31:0] AWADDR, WDATA, ARADDR;
  logic [31:0] RDATA = 32'd0;

  always #5 ACLK = ~ACLK;

  eeprom_axi_sequencer #(.POLL_MAX(16'd4)) dut (
    .ACLK(ACLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic       is_read;
    logic       err;
    logic [7:0] rdata;
  } rsp_t;

  logic [63:0] exp_wr_q[$];
  rsp_t        exp_rsp_q[$];

  // Stimulus-side knobs
  int   aw_delay = 0, w_delay = 0, ar_delay = 0;
  logic stuck_wip = 1'b0;
  localparam int WIP_POLLS = 2;

  // Peripheral/EEPROM model state, owned by the slave process
  int          aw_wait, w_wait, ar_wait;
  logic        aw_seen = 1'b0, w_seen = 1'b0, have_aw = 1'b0, have_w = 1'b0, ar_pend = 1'b0;
  logic [31:0] cap_awaddr, cap_wdata, rd_val;
  int          frame_n = -1;
  logic [7:0]  fbytes[$];
  logic [7:0]  rx_q[$];
  int          busy_left = 0;
  logic        rx_gate = 1'b0;
  logic        wel = 1'b0;
  int          wip_left = 0;
  int          rdsr_frames = 0;
  logic [7:0]  mem [logic [15:0]];

  task automatic run_frame();
    logic [7:0]  last;
    logic [15:0] a;
    last = 8'h00;
    busy_left = 2;
    a = {fbytes[1], fbytes[2]};
    case (fbytes[0])
      8'h06: wel = 1'b1;
      8'h02: if (wel) begin mem[a] = fbytes[3]; wip_left = WIP_POLLS; wel = 1'b0; end
      8'h05: begin
        last = {6'd0, wel, (stuck_wip || wip_left > 0)};
        if (wip_left > 0) wip_left--;
        rdsr_frames++;
      end
      8'h03: last = mem.exists(a) ? mem[a] : 8'hFF;
      default: ;
    endcase
    for (int i = 0; i < fbytes.size() - 1; i++) rx_q.push_back(8'h00);
    rx_q.push_back(last);
  endtask

  task automatic process_write(input logic [31:0] a, input logic [31:0] d);
    logic [63:0] e;
    if (exp_wr_q.size() == 0) check_eq("bus_wr_extra", {a, d}, 64'd0);
    else begin
      e = exp_wr_q.pop_front();
      check_eq("bus_wr", {a, d}, e);
    end
    if (a == BASE + 32'hC) begin
      if (d[8]) begin
        frame_n = int'(d[3:0]);
        fbytes.delete();
        rx_q.delete();
      end else if (frame_n > 0) begin
        fbytes.push_back(d[7:0]);
        if (fbytes.size() == frame_n) begin run_frame(); frame_n = -1; end
      end
    end
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] v);
    logic busy, rxne;
    v = 32'd0;
    if (a == BASE + 32'h4) begin
      busy = (busy_left > 0);
      if (busy) busy_left--;
      rxne = (rx_q.size() > 0) && !rx_gate;
      rx_gate = 1'b0;
      v = {30'd0, rxne, busy};
    end else if (a == BASE) begin
      if (rx_q.size() == 0) check_eq("rx_underflow", 1, 0);
      else begin v = {24'd0, rx_q.pop_front()}; rx_gate = 1'b1; end
    end
  endtask

  // Slave: decisions made on the falling edge, handshakes land on the next rising edge.
  always @(negedge ACLK) begin
    if (RST) begin
      AWREADY = 0; WREADY = 0; ARREADY = 0; RVALID = 0; RDATA = 0;
      aw_seen = 0; w_seen = 0; have_aw = 0; have_w = 0; ar_pend = 0; ar_wait = 0;
      frame_n = -1; fbytes.delete(); rx_q.delete();
      busy_left = 0; rx_gate = 0; wel = 0; wip_left = 0;
    end else begin
      if (AWREADY) AWREADY = 0;
      else if (!have_aw) begin
        if (aw_seen) check_eq("aw_hold", AWVALID, 1);
        if (AWVALID) begin
          if (!aw_seen) begin aw_seen = 1; aw_wait = aw_delay; end
          if (aw_wait == 0) begin AWREADY = 1; have_aw = 1; cap_awaddr = AWADDR; aw_seen = 0; end
          else aw_wait--;
        end else aw_seen = 0;
      end
      if (WREADY) WREADY = 0;
      else if (!have_w) begin
        if (w_seen) check_eq("w_hold", WVALID, 1);
        if (WVALID) begin
          if (!w_seen) begin w_seen = 1; w_wait = w_delay; end
          if (w_wait == 0) begin WREADY = 1; have_w = 1; cap_wdata = WDATA; w_seen = 0; end
          else w_wait--;
        end else w_seen = 0;
      end
      if (have_aw && have_w) begin
        process_write(cap_awaddr, cap_wdata);
        have_aw = 0;
        have_w  = 0;
      end
      if (ARREADY) ARREADY = 0;
      else if (ARVALID && !ar_pend) begin
        if (ar_wait == 0) begin ARREADY = 1; ar_pend = 1; do_read(ARADDR, rd_val); ar_wait = ar_delay; end
        else ar_wait--;
      end
      if (RVALID) begin RVALID = 0; ar_pend = 0; end
      else if (ar_pend && RREADY) begin RVALID = 1; RDATA = rd_val; end
    end
  end

  task automatic exp_tx(input logic [8:0] w);
    exp_wr_q.push_back({BASE + 32'hC, 23'd0, w});
  endtask

  task automatic exp_write(input logic [15:0] a, input logic [7:0] d, input int npolls, input logic err);
    rsp_t r;
    exp_tx(9'h101); exp_tx(9'h006);
    exp_tx(9'h104); exp_tx(9'h002); exp_tx({1'b0, a[15:8]}); exp_tx({1'b0, a[7:0]}); exp_tx({1'b0, d});
    for (int i = 0; i < npolls; i++) begin exp_tx(9'h102); exp_tx(9'h005); exp_tx(9'h000); end
    r.is_read = 1'b0; r.err = err; r.rdata = 8'h00;
    exp_rsp_q.push_back(r);
  endtask

  task automatic exp_read(input logic [15:0] a, input logic [7:0] d);
    rsp_t r;
    exp_tx(9'h104); exp_tx(9'h003); exp_tx({1'b0, a[15:8]}); exp_tx({1'b0, a[7:0]}); exp_tx(9'h000);
    r.is_read = 1'b1; r.err = 1'b0; r.rdata = d;
    exp_rsp_q.push_back(r);
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 500; i++) begin
      @(posedge ACLK); #1;
      if (REQ_READY) break;
    end
    check_eq(tag, REQ_READY, 1);
  endtask

  // Issue one request, then scramble inputs and hold REQ_VALID to show both are ignored while busy.
  task automatic issue(input logic wr, input logic [15:0] a, input logic [7:0] d);
    REQ_VALID = 1; REQ_WRITE = wr; REQ_ADDR = a; REQ_WDATA = d;
    @(posedge ACLK); #1;
    REQ_WRITE = ~wr; REQ_ADDR = ~a; REQ_WDATA = ~d;
    check_eq("accept_ready_low", REQ_READY, 0);
  endtask

  task automatic wait_rsp(input string tag);
    logic got;
    rsp_t e;
    got = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge ACLK); #1;
      if (RSP_VALID) begin got = 1; break; end
    end
    REQ_VALID = 0;
    check_eq({tag, "_rsp_seen"}, got, 1);
    if (got && exp_rsp_q.size() > 0) begin
      e = exp_rsp_q.pop_front();
      check_eq({tag, "_err"}, RSP_ERR, e.err);
      if (e.is_read || e.err) check_eq({tag, "_rdata"}, RSP_RDATA, e.rdata);
      check_eq({tag, "_tx_drained"}, exp_wr_q.size(), 0);
      @(posedge ACLK); #1;
      check_eq({tag, "_pulse_one"}, RSP_VALID, 0);
      check_eq({tag, "_ready_back"}, REQ_READY, 1);
    end
  endtask

  initial begin
    int   snap;
    logic found;
    REQ_VALID = 1; REQ_WRITE = 1; REQ_ADDR = 16'h1111; REQ_WDATA = 8'h22;
    repeat (3) @(posedge ACLK);
    #1;
    check_eq("rst_ctl", {AWVALID, WVALID, ARVALID, RREADY, REQ_READY, RSP_VALID, RSP_ERR}, 0);
    check_eq("rst_aw_w", {AWADDR, WDATA}, 0);
    check_eq("rst_ar_rsp", {ARADDR, RSP_RDATA}, 0);
    exp_wr_q.push_back({BASE + 32'h8, 32'h30000000});
    REQ_VALID = 0;
    RST = 0;
    wait_ready("cfg_ready");
    check_eq("cfg_written", exp_wr_q.size(), 0);

    exp_write(16'h00F0, 8'hAA, WIP_POLLS + 1, 1'b0);
    issue(1'b1, 16'h00F0, 8'hAA);
    wait_rsp("wr_f0");
    exp_read(16'h00F0, 8'hAA);
    wait_ready("rd_f0_ready");
    issue(1'b0, 16'h00F0, 8'h00);
    wait_rsp("rd_f0");

    aw_delay = 3;
    exp_write(16'h1234, 8'h5C, WIP_POLLS + 1, 1'b0);
    issue(1'b1, 16'h1234, 8'h5C);
    wait_rsp("wr_aw_late");
    aw_delay = 0; w_delay = 3;
    exp_write(16'hBEEF, 8'h3C, WIP_POLLS + 1, 1'b0);
    issue(1'b1, 16'hBEEF, 8'h3C);
    wait_rsp("wr_w_late");
    w_delay = 0; ar_delay = 2;
    exp_read(16'h1234, 8'h5C);
    issue(1'b0, 16'h1234, 8'h00);
    wait_rsp("rd_1234");
    exp_read(16'hBEEF, 8'h3C);
    issue(1'b0, 16'hBEEF, 8'h00);
    wait_rsp("rd_beef");
    ar_delay = 0;

    stuck_wip = 1;
    snap = rdsr_frames;
    exp_write(16'h0010, 8'h77, 4, 1'b1);
    issue(1'b1, 16'h0010, 8'h77);
    wait_rsp("timeout");
    check_eq("timeout_polls", rdsr_frames - snap, 4);
    stuck_wip = 0;

    aw_delay = 4;
    exp_write(16'h0200, 8'h99, WIP_POLLS + 1, 1'b0);
    issue(1'b1, 16'h0200, 8'h99);
    found = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge ACLK); #1;
      if (AWVALID && AWADDR == BASE + 32'hC && WDATA[8:0] == 9'h002) begin found = 1; break; end
    end
    check_eq("wr_frame_reached", found, 1);
    RST = 1; REQ_VALID = 1; REQ_WRITE = 0;
    exp_wr_q.delete();
    exp_rsp_q.delete();
    exp_wr_q.push_back({BASE + 32'h8, 32'h30000000});
    @(posedge ACLK); #1;
    check_eq("rst_mid_drop", {AWVALID, WVALID, ARVALID, RREADY, REQ_READY, RSP_VALID}, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge ACLK); #1;
      check_eq("rst_hold_ctl", {AWVALID, WVALID, ARVALID, RREADY, REQ_READY, RSP_VALID}, 0);
      check_eq("rst_hold_addr", {AWADDR, ARADDR}, 0);
    end
    RST = 0; REQ_VALID = 0; aw_delay = 0;
    wait_ready("cfg_again_ready");
    check_eq("cfg_reissued", exp_wr_q.size(), 0);

    exp_read(16'h00F0, 8'hAA);
    issue(1'b0, 16'h00F0, 8'h00);
    wait_rsp("rd_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
